// File: rtl/wbc2axil_pkg.sv
// Shared state encoding and AXI constants for the
// Wishbone-classic to AXI4-Lite master bridge.
package wbc2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WRESP,
        RD_A,
        RD_R,
        ACK,
        DRAIN
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic e;
        e = 1'b0;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   e = 1'b0;
            RESP_SLVERR, RESP_DECERR: e = 1'b1;
            default:                  e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/wbc2axil_master.sv
// Wishbone classic slave to AXI4-Lite master, one transaction at a time.
// Define WBC2AXIL_ERR_EN to map SLVERR/DECERR responses onto o_wb_err.
module wbc2axil_master
    import wbc2axil_pkg::*;
#(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_axi_awvalid,
    input  logic            i_axi_awready,
    output logic [AW+1:0]   o_axi_awaddr,
    output logic [2:0]      o_axi_awprot,
    output logic            o_axi_wvalid,
    input  logic            i_axi_wready,
    output logic [DW-1:0]   o_axi_wdata,
    output logic [DW/8-1:0] o_axi_wstrb,
    input  logic            i_axi_bvalid,
    output logic            o_axi_bready,
    input  logic [1:0]      i_axi_bresp,
    output logic            o_axi_arvalid,
    input  logic            i_axi_arready,
    output logic [AW+1:0]   o_axi_araddr,
    output logic [2:0]      o_axi_arprot,
    input  logic            i_axi_rvalid,
    output logic            o_axi_rready,
    input  logic [DW-1:0]   i_axi_rdata,
    input  logic [1:0]      i_axi_rresp
);

`ifdef WBC2AXIL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    generate
        if (DW != 32) begin : g_dw_check
            $error("wbc2axil_master: only DW=32 is supported");
        end
    endgenerate

    state_t          state;
    logic            we;
    logic [AW+1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            awvalid;
    logic            wvalid;
    logic            bready;
    logic            arvalid;
    logic            rready;
    logic            ack;
    logic            err;

    logic aw_done;
    logic w_done;
    logic ar_done;
    logic b_fire;
    logic r_fire;
    logic b_fail;
    logic r_fail;

    // Channel completion and response classification for this cycle
    always_comb begin
        aw_done = !awvalid || i_axi_awready;
        w_done  = !wvalid || i_axi_wready;
        ar_done = !arvalid || i_axi_arready;
        b_fire  = bready && i_axi_bvalid;
        r_fire  = rready && i_axi_rvalid;
        b_fail  = ERR_EN && resp_is_err(i_axi_bresp);
        r_fail  = ERR_EN && resp_is_err(i_axi_rresp);
    end

    // Transaction FSM with registered AXI valids/readies and Wishbone reply
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            o_wb_data <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (awvalid && i_axi_awready) awvalid <= 1'b0;
            if (wvalid && i_axi_wready)   wvalid  <= 1'b0;
            if (arvalid && i_axi_arready) arvalid <= 1'b0;
            if (r_fire)                   o_wb_data <= i_axi_rdata;
            unique case (state)
                IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        we    <= i_wb_we;
                        addr  <= {i_wb_addr, 2'b00};
                        wdata <= i_wb_data;
                        wstrb <= i_wb_sel;
                        if (i_wb_we) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= i_wb_cyc ? WRESP : DRAIN;
                    end else if (!i_wb_cyc) begin
                        state <= DRAIN;
                    end
                end
                WRESP: begin
                    if (b_fire) begin
                        bready <= 1'b0;
                        ack    <= i_wb_cyc && !b_fail;
                        err    <= i_wb_cyc && b_fail;
                        state  <= i_wb_cyc ? ACK : IDLE;
                    end else if (!i_wb_cyc) begin
                        state <= DRAIN;
                    end
                end
                RD_A: begin
                    if (i_axi_arready) begin
                        rready <= 1'b1;
                        state  <= i_wb_cyc ? RD_R : DRAIN;
                    end else if (!i_wb_cyc) begin
                        state <= DRAIN;
                    end
                end
                RD_R: begin
                    if (r_fire) begin
                        rready <= 1'b0;
                        ack    <= i_wb_cyc && !r_fail;
                        err    <= i_wb_cyc && r_fail;
                        state  <= i_wb_cyc ? ACK : IDLE;
                    end else if (!i_wb_cyc) begin
                        state <= DRAIN;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    // Abandoned by the master: finish the AXI side silently
                    if (we) begin
                        if (b_fire) begin
                            bready <= 1'b0;
                            state  <= IDLE;
                        end else if (!bready && aw_done && w_done) begin
                            bready <= 1'b1;
                        end
                    end else begin
                        if (r_fire) begin
                            rready <= 1'b0;
                            state  <= IDLE;
                        end else if (!rready && ar_done) begin
                            rready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_wb_ack      = ack;
    assign o_wb_err      = err;
    assign o_axi_awvalid = awvalid;
    assign o_axi_awaddr  = addr;
    assign o_axi_awprot  = PROT_DEFAULT;
    assign o_axi_wvalid  = wvalid;
    assign o_axi_wdata   = wdata;
    assign o_axi_wstrb   = wstrb;
    assign o_axi_bready  = bready;
    assign o_axi_arvalid = arvalid;
    assign o_axi_araddr  = addr;
    assign o_axi_arprot  = PROT_DEFAULT;
    assign o_axi_rready  = rready;

endmodule

// File: tb/tb_wbc2axil_master.sv
// Self-checking bench for wbc2axil_master: directed Wishbone transfers
// against a delay-programmable AXI4-Lite slave, with a response scoreboard.
`timescale 1ns/1ps
module tb_wbc2axil_master;
    import wbc2axil_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;

`ifdef WBC2AXIL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_wdata;
    logic [3:0]    wb_sel;
    logic          wb_ack, wb_err;
    logic [31:0]   wb_rdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW+1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    wbc2axil_master #(.AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
        .o_wb_ack(wb_ack), .o_wb_err(wb_err), .o_wb_data(wb_rdata),
        .o_axi_awvalid(awvalid), .i_axi_awready(awready),
        .o_axi_awaddr(awaddr), .o_axi_awprot(awprot),
        .o_axi_wvalid(wvalid), .i_axi_wready(wready),
        .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
        .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bresp(bresp),
        .o_axi_arvalid(arvalid), .i_axi_arready(arready),
        .o_axi_araddr(araddr), .o_axi_arprot(arprot),
        .i_axi_rvalid(rvalid), .o_axi_rready(rready),
        .i_axi_rdata(rdata), .i_axi_rresp(rresp)
    );

    typedef struct {
        logic        ack;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // slave configuration and per-transaction bookkeeping
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          aw_beats, w_beats, ar_beats;
    logic        b_sent, r_sent;
    logic [31:0] got_awaddr, got_araddr, got_wdata;
    logic [3:0]  got_wstrb;

    logic        aw_hs = 1'b0, w_hs = 1'b0, ar_hs = 1'b0;
    logic        b_hs = 1'b0, r_hs = 1'b0;
    logic        p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // handshakes seen at each rising edge
    always @(posedge clk) begin
        aw_hs <= awvalid && awready;
        w_hs  <= wvalid && wready;
        ar_hs <= arvalid && arready;
        b_hs  <= bvalid && bready;
        r_hs  <= rvalid && rready;
    end

    // AXI slave model plus payload-stability and ordering checks
    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                awready = 0; wready = 0; arready = 0;
                bvalid = 0; rvalid = 0;
                p_awv = 0; p_wv = 0; p_arv = 0;
            end else begin
                if (p_awv && !aw_hs) begin
                    check("awvalid held", awvalid, 1);
                    check("awaddr stable", awaddr, p_awaddr);
                end
                if (p_wv && !w_hs) begin
                    check("wvalid held", wvalid, 1);
                    check("wdata stable", wdata, p_wdata);
                    check("wstrb stable", wstrb, p_wstrb);
                end
                if (p_arv && !ar_hs) begin
                    check("arvalid held", arvalid, 1);
                    check("araddr stable", araddr, p_araddr);
                end
                if (aw_hs) begin
                    awready = 0; aw_beats++;
                end else if (awvalid && !awready) begin
                    if (aw_wait >= aw_dly) begin
                        awready = 1; got_awaddr = awaddr;
                    end else aw_wait++;
                end
                if (w_hs) begin
                    wready = 0; w_beats++;
                end else if (wvalid && !wready) begin
                    if (w_wait >= w_dly) begin
                        wready = 1; got_wdata = wdata; got_wstrb = wstrb;
                    end else w_wait++;
                end
                if (ar_hs) begin
                    arready = 0; ar_beats++;
                end else if (arvalid && !arready) begin
                    if (ar_wait >= ar_dly) begin
                        arready = 1; got_araddr = araddr;
                    end else ar_wait++;
                end
                if (b_hs) bvalid = 0;
                else if (!bvalid && !b_sent && aw_beats == 1 && w_beats == 1) begin
                    if (b_wait >= b_dly) begin
                        bvalid = 1; bresp = cfg_bresp; b_sent = 1;
                    end else b_wait++;
                end
                if (r_hs) rvalid = 0;
                else if (!rvalid && !r_sent && ar_beats == 1) begin
                    if (r_wait >= r_dly) begin
                        rvalid = 1; rresp = cfg_rresp; rdata = cfg_rdata; r_sent = 1;
                    end else r_wait++;
                end
                if (bready)
                    check("bready after AW and W", aw_beats == 1 && w_beats == 1, 1);
                if (rready)
                    check("rready after AR", ar_beats == 1, 1);
                p_awv = awvalid; p_awaddr = awaddr;
                p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
                p_arv = arvalid; p_araddr = araddr;
            end
        end
    end

    // Wishbone response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (wb_ack || wb_err)) begin
                if (sb.size() == 0) begin
                    check("unexpected wb response", {wb_ack, wb_err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("wb ack", wb_ack, e.ack);
                    check("wb err", wb_err, e.err);
                    if (e.chk) check("wb read data", wb_rdata, e.data);
                end
            end
        end
    end

    task automatic start_txn(input logic w, input logic [AW-1:0] a,
                             input logic [31:0] d, input logic [3:0] sel);
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_beats = 0; w_beats = 0; ar_beats = 0;
        b_sent = 0; r_sent = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = w;
        wb_addr = a; wb_wdata = d; wb_sel = sel;
    endtask

    // one Wishbone transfer; latency counts cycles from stb through ack
    task automatic wb_xfer(input string name, input logic w,
                           input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] sel, input logic eack,
                           input logic eerr, input logic [31:0] edata,
                           input int elat);
        exp_t e;
        int   lat;
        logic done;
        e.ack = eack; e.err = eerr; e.chk = !w && eack; e.data = edata;
        sb.push_back(e);
        start_txn(w, a, d, sel);
        lat = 1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (wb_ack || wb_err) done = 1;
        end
        check({name, " completed"}, done, 1);
        if (done) check({name, " latency"}, lat, elat);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
    endtask

    task automatic set_dly(input int daw, input int dw, input int dar,
                           input int db, input int dr);
        aw_dly = daw; w_dly = dw; ar_dly = dar; b_dly = db; r_dly = dr;
    endtask

    initial begin
        logic seen;
        reset = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
        wb_addr = 0; wb_wdata = 0; wb_sel = 0;
        cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY; cfg_rdata = 0;
        set_dly(0, 0, 0, 0, 0);
        start_txn(0, 0, 0, 0);
        wb_cyc = 0; wb_stb = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("reset ack", wb_ack, 0);
        check("reset err", wb_err, 0);
        check("reset rdata", wb_rdata, 0);
        check("reset valids", {awvalid, wvalid, arvalid}, 0);
        check("reset readies", {bready, rready}, 0);
        check("reset prot", {awprot, arprot}, 0);
        check("reset state", dut.state, IDLE);

        // plain write, everything ready
        wb_xfer("wr basic", 1, 30'h0000_0400, 32'hDEAD_BEEF, 4'b0011,
                1, 0, 0, 4);
        check("wr basic awaddr", got_awaddr, 32'h0000_1000);
        check("wr basic wdata", got_wdata, 32'hDEAD_BEEF);
        check("wr basic wstrb", got_wstrb, 4'b0011);
        check("wr basic beats", {aw_beats[3:0], w_beats[3:0]}, 8'h11);

        // read with slow arready and rvalid
        cfg_rdata = 32'h1234_5678;
        set_dly(0, 0, 2, 0, 5);
        wb_xfer("rd slow", 0, 30'h0000_0800, 0, 4'hF, 1, 0,
                32'h1234_5678, 11);
        check("rd slow araddr", got_araddr, 32'h0000_2000);
        check("rd slow beats", ar_beats, 1);

        // awready well ahead of wready, top word address
        set_dly(0, 3, 0, 0, 0);
        wb_xfer("wr skew", 1, 30'h3FFF_FFFF, 32'hA5A5_5A5A, 4'b1111,
                1, 0, 0, 7);
        check("wr skew awaddr", got_awaddr, 32'hFFFF_FFFC);
        check("wr skew wdata", got_wdata, 32'hA5A5_5A5A);
        check("wr skew beats", {aw_beats[3:0], w_beats[3:0]}, 8'h11);

        // error responses
        set_dly(0, 0, 0, 0, 0);
        cfg_rresp = RESP_SLVERR; cfg_rdata = 32'hCAFE_F00D;
        wb_xfer("rd slverr", 0, 30'h0000_0010, 0, 4'hF, !ERR_EN, ERR_EN,
                32'hCAFE_F00D, 4);
        check("rd slverr data", wb_rdata, 32'hCAFE_F00D);
        cfg_bresp = RESP_DECERR;
        wb_xfer("wr decerr", 1, 30'h0000_0020, 32'h0000_0001, 4'b0001,
                !ERR_EN, ERR_EN, 0, 4);
        cfg_bresp = RESP_OKAY;
        cfg_rresp = RESP_EXOKAY; cfg_rdata = 32'h0F0F_0F0F;
        wb_xfer("rd exokay", 0, 30'h0000_0030, 0, 4'hF, 1, 0,
                32'h0F0F_0F0F, 4);
        cfg_rresp = RESP_OKAY;

        // master abandons a read while it waits for rvalid
        set_dly(0, 0, 0, 0, 4);
        cfg_rdata = 32'h0BAD_0BAD;
        start_txn(0, 30'h0000_0040, 0, 4'hF);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rready) seen = 1;
        end
        check("abort rready seen", seen, 1);
        wb_cyc = 0; wb_stb = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (r_sent && !rvalid) seen = 1;
        end
        check("abort read completed", seen, 1);
        repeat (2) @(negedge clk);
        check("abort rready low", rready, 0);
        check("abort ar beats", ar_beats, 1);
        check("abort state", dut.state, IDLE);
        set_dly(0, 0, 0, 0, 0);
        cfg_rdata = 32'h5555_AAAA;
        wb_xfer("rd after abort", 0, 30'h0000_0044, 0, 4'hF, 1, 0,
                32'h5555_AAAA, 4);

        // reset while waiting for the write response
        set_dly(0, 0, 0, 6, 0);
        start_txn(1, 30'h0000_0050, 32'h1111_2222, 4'hF);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bready) seen = 1;
        end
        check("rst bready seen", seen, 1);
        reset = 1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
        check("rst mid valids", {awvalid, wvalid, arvalid}, 0);
        check("rst mid readies", {bready, rready}, 0);
        check("rst mid ack", {wb_ack, wb_err}, 0);
        check("rst mid state", dut.state, IDLE);
        reset = 0;
        @(negedge clk);
        set_dly(1, 0, 0, 0, 0);
        wb_xfer("wr after reset", 1, 30'h0000_0060, 32'h7777_8888, 4'b1100,
                1, 0, 0, 5);
        check("wr after reset awaddr", got_awaddr, 32'h0000_0180);

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
